softmax_frame_ctrl: RTL and testbench
=====================================

SOFTMAX_FRAME_CTRL -- requirements
Module: softmax_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, FP32 word width.
REQ-002 SHALL have parameter NUMBER_OF_DATA, default 10, words per frame (range 2..15).
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum idle cycles in DRAIN.
REQ-004 SHALL have port clock_i  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid_i  in  1  input word valid.
REQ-007 SHALL have port in_data_i  in  DATA_SIZE  input FP32 word.
REQ-008 SHALL have port in_ready_o  out  1  controller can accept a word.
REQ-009 SHALL have port dp_start_o  out  1  datapath word strobe.
REQ-010 SHALL have port dp_data_o  out  DATA_SIZE  word issued to the datapath.
REQ-011 SHALL have port dp_max_o  out  DATA_SIZE  frame maximum, held through ISSUE and DRAIN.
REQ-012 SHALL have port dp_result_valid_i  in  1  datapath result valid.
REQ-013 SHALL have port dp_result_i  in  DATA_SIZE  datapath result word.
REQ-014 SHALL have port out_valid_o  out  1  result word valid.
REQ-015 SHALL have port out_data_o  out  DATA_SIZE  result word.
REQ-016 SHALL have port out_last_o  out  1  marks the final result word of the frame.
REQ-017 SHALL have port frame_done_o  out  1  one-cycle pulse at frame completion.
REQ-018 SHALL have port timeout_o  out  1  sticky timeout flag, cleared at the next accepted frame start.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, ISSUE, DRAIN, DONE.
REQ-020 SHALL define handshake: a word transfers when in_valid_i and in_ready_o are both 1 on a rising edge.
REQ-021 SHALL drive in_ready_o to 1 only in IDLE and LOAD, registered, so it is 0 for the first cycle after reset release.
REQ-022 IDLE: on the first transfer, SHALL store the word at buf[0], set max to it, clear timeout_o, and go to LOAD.
REQ-023 LOAD: SHALL store each transfer at buf[count]; after the NUMBER_OF_DATA-th transfer SHALL go to ISSUE on the next edge.
REQ-024 Max update SHALL be FP32 sign-magnitude compare:
  - different signs: the positive word is larger; +0 equals -0.
  - both positive: the larger bits[30:0] wins.
  - both negative: the smaller bits[30:0] wins.
  - ties keep the stored max; NaN compares by these bit rules.
REQ-025 ISSUE: SHALL assert dp_start_o for exactly NUMBER_OF_DATA consecutive cycles, with dp_data_o = buf[k] in cycle k (k = 0..N-1), then go to DRAIN.
REQ-026 dp_max_o SHALL be stable from the first ISSUE cycle until leaving DRAIN.
REQ-027 SHALL count results in both ISSUE and DRAIN; each dp_result_valid_i SHALL produce out_valid_o=1 and out_data_o=dp_result_i one cycle later (registered).
REQ-028 SHALL assert out_last_o together with the NUMBER_OF_DATA-th out_valid_o.
REQ-029 SHALL go from DRAIN to DONE in the cycle after the Nth result is captured.
REQ-030 SHALL ignore results beyond N, and results arriving in IDLE, LOAD or DONE.
REQ-031 DRAIN: SHALL reload an idle counter on every result; if TIMEOUT cycles pass with no result, SHALL set timeout_o, skip frame_done_o, and go to IDLE.
REQ-032 DONE: SHALL pulse frame_done_o for one cycle, then go to IDLE.
REQ-033 SHALL keep dp_start_o, out_valid_o, out_last_o and frame_done_o at 0 outside the states that drive them.
REQ-034 SHALL have throughput of one frame per at most 2N+3+pipeline-latency cycles; the input is not accepted during ISSUE, DRAIN or DONE.

Reset
REQ-035 reset_i high SHALL asynchronously force state IDLE, counters 0, max 0, and all outputs 0 (including in_ready_o and timeout_o).
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; buffer contents need no reset.

Verification
REQ-037 Load words C05060D2, 40A5D0A4, BF3A1674, 401D24F6, BE3BD70A, 3F461F7D, C0350DF4, 40BEEE67, C0A6D2C4, 3F9DF3B6 back-to-back -> dp_max_o=40BEEE67; ten dp_start_o cycles replay the words in order.
REQ-038 All-negative frame (BF800000 x 9 plus C0000000 in slot 0) -> dp_max_o=BF800000; frame of 80000000 and 00000000 -> max stays the first word.
REQ-039 Datapath model returns 10 results with a gap of 3 cycles each -> 10 out_valid_o, out_last_o only on the 10th, frame_done_o one cycle after DRAIN exits.
REQ-040 Model returns only 7 results -> timeout_o=1 after TIMEOUT idle cycles, no frame_done_o, in_ready_o returns to 1; timeout_o clears on the next frame start.
REQ-041 in_valid_i toggling every other cycle -> exactly 10 transfers; in_ready_o=0 throughout ISSUE and DRAIN.
REQ-042 reset_i pulsed during ISSUE cycle 4 -> all outputs 0 immediately; the next frame processes normally.

Source files
------------

// File: rtl/softmax_frame_ctrl.sv
// Frame controller for a softmax datapath: buffers N FP32 words while tracking their maximum,
// replays them to the datapath, then collects N results with an idle watchdog.
module softmax_frame_ctrl #(
  parameter int DATA_SIZE      = 32,
  parameter int NUMBER_OF_DATA = 10,
  parameter int TIMEOUT        = 255
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  input  logic [DATA_SIZE-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic                 dp_start_o,
  output logic [DATA_SIZE-1:0] dp_data_o,
  output logic [DATA_SIZE-1:0] dp_max_o,
  input  logic                 dp_result_valid_i,
  input  logic [DATA_SIZE-1:0] dp_result_i,
  output logic                 out_valid_o,
  output logic [DATA_SIZE-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 frame_done_o,
  output logic                 timeout_o
);

  localparam int CW = $clog2(NUMBER_OF_DATA + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUMBER_OF_DATA - 1);
  localparam logic [CW-1:0] N_CNT    = CW'(NUMBER_OF_DATA);
  localparam logic [TW-1:0] IDLE_LIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // Handshake: a word moves on a rising edge where in_valid_i and in_ready_o are both high;
  // the datapath result port has no backpressure, dp_result_valid_i is sampled every edge.

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        res_cnt_q, res_cnt_d;
  logic [TW-1:0]        idle_q, idle_d;
  logic [DATA_SIZE-1:0] max_q, max_d;
  logic                 in_ready_q, in_ready_d;
  logic                 dp_start_q, dp_start_d;
  logic [DATA_SIZE-1:0] dp_data_q, dp_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 frame_done_q, frame_done_d;
  logic                 timeout_q, timeout_d;

  logic [DATA_SIZE-1:0] mem_q [NUMBER_OF_DATA];
  logic                 mem_we;
  logic [CW-1:0]        mem_waddr;
  logic [CW-1:0]        issue_nxt;
  logic                 xfer;
  logic                 res_take;

  // Sign-magnitude ordering: +0 and -0 compare equal, negatives order by reversed magnitude.
  function automatic logic is_greater(input logic [DATA_SIZE-1:0] a,
                                      input logic [DATA_SIZE-1:0] b);
    logic [DATA_SIZE-2:0] ma;
    logic [DATA_SIZE-2:0] mb;
    ma = a[DATA_SIZE-2:0];
    mb = b[DATA_SIZE-2:0];
    if (a[DATA_SIZE-1] != b[DATA_SIZE-1])
      is_greater = !a[DATA_SIZE-1] && ((ma | mb) != '0);
    else if (!a[DATA_SIZE-1])
      is_greater = ma > mb;
    else
      is_greater = ma < mb;
  endfunction

  assign xfer      = in_valid_i && in_ready_q;
  assign res_take  = dp_result_valid_i && (res_cnt_q != N_CNT) &&
                     ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign issue_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    res_cnt_d    = res_cnt_q;
    idle_d       = idle_q;
    max_d        = max_q;
    dp_start_d   = 1'b0;
    dp_data_d    = dp_data_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_last_d   = 1'b0;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    mem_we       = 1'b0;
    mem_waddr    = cnt_q;

    if (res_take) begin
      out_valid_d = 1'b1;
      out_data_d  = dp_result_i;
      out_last_d  = (res_cnt_q == LAST_IDX);
      res_cnt_d   = res_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          max_d     = in_data_i;
          timeout_d = 1'b0;
          cnt_d     = CW'(1);
          res_cnt_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          mem_we = 1'b1;
          if (is_greater(in_data_i, max_q)) max_d = in_data_i;
          if (cnt_q == LAST_IDX) begin
            // Slot 0 is already stored, so the first replay word can be registered now.
            state_d    = S_ISSUE;
            cnt_d      = '0;
            dp_start_d = 1'b1;
            dp_data_d  = mem_q[0];
          end else begin
            cnt_d = issue_nxt;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          cnt_d      = issue_nxt;
          dp_start_d = 1'b1;
          dp_data_d  = mem_q[issue_nxt];
        end
      end
      S_DRAIN: begin
        if (res_cnt_q == N_CNT) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else if (dp_result_valid_i) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      res_cnt_q    <= '0;
      idle_q       <= '0;
      max_q        <= '0;
      in_ready_q   <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_data_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      res_cnt_q    <= res_cnt_d;
      idle_q       <= idle_d;
      max_q        <= max_d;
      in_ready_q   <= in_ready_d;
      dp_start_q   <= dp_start_d;
      dp_data_q    <= dp_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[mem_waddr] <= in_data_i;
  end

  assign in_ready_o   = in_ready_q;
  assign dp_start_o   = dp_start_q;
  assign dp_data_o    = dp_data_q;
  assign dp_max_o     = max_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_last_o   = out_last_q;
  assign frame_done_o = frame_done_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_softmax_frame_ctrl.sv
// Bench for softmax_frame_ctrl: directed and random frames against a frame-level reference model
// (ordered-key maximum, replay list, result queue, watchdog timing).
module tb_softmax_frame_ctrl;

  localparam int N   = 10;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        dp_start_o;
  logic [31:0] dp_data_o;
  logic [31:0] dp_max_o;
  logic        dp_result_valid_i;
  logic [31:0] dp_result_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        frame_done_o;
  logic        timeout_o;

  always #5 clk = ~clk;

  softmax_frame_ctrl #(.DATA_SIZE(32), .NUMBER_OF_DATA(N), .TIMEOUT(TMO)) dut (
    .clock_i           (clk),
    .reset_i           (reset_i),
    .in_valid_i        (in_valid_i),
    .in_data_i         (in_data_i),
    .in_ready_o        (in_ready_o),
    .dp_start_o        (dp_start_o),
    .dp_data_o         (dp_data_o),
    .dp_max_o          (dp_max_o),
    .dp_result_valid_i (dp_result_valid_i),
    .dp_result_i       (dp_result_i),
    .out_valid_o       (out_valid_o),
    .out_data_o        (out_data_o),
    .out_last_o        (out_last_o),
    .frame_done_o      (frame_done_o),
    .timeout_o         (timeout_o)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] frame_w [N];
  logic [31:0] exp_q [$];
  bit          tmo_sticky = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Map a word onto a signed integer line: +m -> m, -m -> -m, so both zeros land on 0.
  function automatic longint order_key(input logic [31:0] w);
    longint mag;
    mag = longint'(w[30:0]);
    return w[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] ref_max();
    logic [31:0] m;
    m = frame_w[0];
    for (int i = 1; i < N; i++)
      if (order_key(frame_w[i]) > order_key(m)) m = frame_w[i];
    return m;
  endfunction

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_in_ready"},   32'(in_ready_o),   32'h0);
    check_val({pfx, "_dp_start"},   32'(dp_start_o),   32'h0);
    check_val({pfx, "_dp_data"},    dp_data_o,         32'h0);
    check_val({pfx, "_dp_max"},     dp_max_o,          32'h0);
    check_val({pfx, "_out_valid"},  32'(out_valid_o),  32'h0);
    check_val({pfx, "_out_data"},   out_data_o,        32'h0);
    check_val({pfx, "_out_last"},   32'(out_last_o),   32'h0);
    check_val({pfx, "_frame_done"}, 32'(frame_done_o), 32'h0);
    check_val({pfx, "_timeout"},    32'(timeout_o),    32'h0);
  endtask

  task automatic apply_reset(input bit immediate);
    in_valid_i        = 1'b0;
    in_data_i         = '0;
    dp_result_valid_i = 1'b0;
    dp_result_i       = '0;
    reset_i           = 1'b1;
    #2;
    if (immediate) check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    reset_i = 1'b0;
    @(negedge clk);
    check_val("rdy_first_cycle", 32'(in_ready_o), 32'h0);
    @(negedge clk);
    check_val("rdy_idle", 32'(in_ready_o), 32'h1);
    tmo_sticky = 1'b0;
    exp_q.delete();
  endtask

  // One frame: load frame_w, answer the replay with n_res results, check everything per cycle.
  task automatic run_frame(input int n_res, input int gmin, input int gmax, input int lat,
                           input bit toggle, input int rst_k);
    int          cyc = 0;
    int          word_idx = 0;
    int          issue_idx = 0;
    int          res_sent = 0;
    int          out_cnt = 0;
    int          done_cnt = 0;
    int          next_res = 0;
    int          last_res = -1000;
    int          last_out = -1000;
    bit          started = 1'b0;
    bit          prev_start = 1'b0;
    bit          prev_cnt = 1'b0;
    bit          cnt_now;
    bit          tmo_seen = 1'b0;
    bit          exit_now = 1'b0;
    bit          exp_done;
    bit          exp_tmo;
    logic [31:0] exp_max;
    logic [31:0] d;
    exp_max = ref_max();
    exp_q.delete();
    while (!exit_now && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      cnt_now = 1'b0;
      if (word_idx < N) begin
        in_valid_i = !toggle || cyc[0];
        in_data_i  = frame_w[word_idx];
      end else begin
        // Offer junk words while replay is running; none may be accepted.
        in_valid_i = prev_start && (issue_idx < N);
        in_data_i  = $urandom;
      end
      if (started && res_sent < n_res && cyc >= next_res) begin
        d = $urandom;
        dp_result_valid_i = 1'b1;
        dp_result_i       = d;
        if (res_sent < N) begin
          exp_q.push_back(d);
          cnt_now = 1'b1;
        end
        res_sent++;
        last_res = cyc;
        next_res = cyc + 1 + int'($urandom_range(gmax, gmin));
      end else begin
        dp_result_valid_i = 1'b0;
        dp_result_i       = $urandom;
      end

      @(negedge clk);
      exp_done = (out_cnt == N) && (cyc == last_out + 1);
      check_val("out_valid", 32'(out_valid_o), 32'(prev_cnt));
      if (out_valid_o) begin
        if (exp_q.size() > 0) check_val("out_data", out_data_o, exp_q.pop_front());
        check_val("out_last", 32'(out_last_o), 32'(out_cnt == N - 1));
        out_cnt++;
        last_out = cyc;
      end else begin
        check_val("out_last_idle", 32'(out_last_o), 32'h0);
      end
      check_val("frame_done", 32'(frame_done_o), 32'(exp_done));
      if (frame_done_o) done_cnt++;

      if (dp_start_o) begin
        if (!started) begin
          started  = 1'b1;
          next_res = cyc + lat;
          check_val("xfer_count", 32'(word_idx), 32'(N));
          check_val("tmo_clr", 32'(timeout_o), 32'h0);
        end
        if (issue_idx < N) check_val("dp_data", dp_data_o, frame_w[issue_idx]);
        if (issue_idx == rst_k) begin
          apply_reset(1'b1);
          return;
        end
        issue_idx++;
      end
      prev_start = dp_start_o;

      if (started) begin
        exp_tmo = (n_res < N) && (cyc == last_res + TMO + 1);
        check_val("dp_max", dp_max_o, exp_max);
        check_val("timeout", 32'(timeout_o), 32'(exp_tmo));
        check_val("rdy_busy", 32'(in_ready_o), 32'(timeout_o));
        if (timeout_o) begin
          tmo_seen = 1'b1;
          exit_now = 1'b1;
        end
      end

      if (in_valid_i && in_ready_o) begin
        if (word_idx == 0) begin
          check_val("tmo_pre", 32'(timeout_o), 32'(tmo_sticky));
          tmo_sticky = 1'b0;
        end
        word_idx++;
      end
      if (frame_done_o) exit_now = 1'b1;
      prev_cnt = cnt_now;
    end
    in_valid_i        = 1'b0;
    dp_result_valid_i = 1'b0;
    check_val("issue_count", 32'(issue_idx), 32'(N));
    check_val("xfer_final", 32'(word_idx), 32'(N));
    if (n_res >= N) begin
      check_val("done_cnt", 32'(done_cnt), 32'h1);
      check_val("out_cnt", 32'(out_cnt), 32'(N));
    end else begin
      check_val("done_cnt", 32'(done_cnt), 32'h0);
      check_val("out_cnt", 32'(out_cnt), 32'(n_res));
      check_val("tmo_seen", 32'(tmo_seen), 32'h1);
      tmo_sticky = 1'b1;
    end
  endtask

  task automatic random_words();
    int sel;
    for (int i = 0; i < N; i++) begin
      sel = int'($urandom_range(7, 0));
      if (sel == 0)                frame_w[i] = 32'h8000_0000;
      else if (sel == 1)           frame_w[i] = 32'h0000_0000;
      else if (sel == 2 && i > 0)  frame_w[i] = frame_w[i-1];
      else                         frame_w[i] = $urandom;
    end
  endtask

  initial begin
    int n_res;
    reset_i = 1'b1;
    apply_reset(1'b0);

    frame_w = '{32'hC05060D2, 32'h40A5D0A4, 32'hBF3A1674, 32'h401D24F6, 32'hBE3BD70A,
                32'h3F461F7D, 32'hC0350DF4, 32'h40BEEE67, 32'hC0A6D2C4, 32'h3F9DF3B6};
    run_frame(N, 0, 2, 2, 1'b0, -1);

    frame_w[0] = 32'hC000_0000;
    for (int i = 1; i < N; i++) frame_w[i] = 32'hBF80_0000;
    run_frame(N, 0, 1, 1, 1'b0, -1);

    for (int i = 0; i < N; i++) frame_w[i] = i[0] ? 32'h0000_0000 : 32'h8000_0000;
    run_frame(N + 2, 0, 0, 1, 1'b0, -1);

    random_words();
    run_frame(N, 3, 3, 3, 1'b0, -1);

    random_words();
    run_frame(7, 3, 3, 2, 1'b0, -1);

    random_words();
    run_frame(N, 0, 2, 2, 1'b1, -1);

    random_words();
    run_frame(N, 0, 2, 2, 1'b0, 4);
    random_words();
    run_frame(N, 1, 2, 2, 1'b0, -1);

    for (int f = 0; f < 20; f++) begin
      random_words();
      n_res = ($urandom_range(3, 0) == 0) ? N + 2 : N;
      run_frame(n_res, 0, int'($urandom_range(4, 0)), int'($urandom_range(5, 1)),
                bit'($urandom_range(1, 0)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
